aes_inv_key_gen: RTL and testbench
==================================

// Module: aes_inv_key_gen
// PURPOSE
//  Reverse-direction AES-128 key schedule for the decryption datapath.
//  - Loaded with the round-10 key, it emits round keys 10,9,...,0, one per accepted transfer.
//  - Uses the inverse recurrence, so the 11 round keys never need to be stored.
//  - Sits between the key-load interface and the inverse-cipher round logic, which consumes keys over a valid/ready handshake.
// PARAMETERS
//  NR        10   number of rounds; the round counter is 4 bits wide
//  KEY_W     128  key width in bits; the width is fixed for AES-128
// PORTS
//  clk          in   1    clock; the only clock
//  nrst         in   1    reset; synchronous, active-low
//  start_i      in   1    load key_i and begin a schedule; sampled only in IDLE
//  key_i        in   128  round-10 key (cipher key when AES_INV_KEY_FWD_EXPAND_EN is defined); w0 = [127:96]
//  key_ready_i  in   1    consumer accepts key_o this cycle
//  key_valid_o  out  1    key_o/rnd_o are valid
//  key_o        out  128  current round key, aes_pkg::aes_128
//  rnd_o        out  4    round index of key_o, 10 down to 0
//  busy_o       out  1    schedule in progress
//  done_o       out  1    one-cycle pulse after round-0 key is accepted
// BEHAVIOUR
//  - Reset (nrst=0 at posedge): state=IDLE; all outputs and key_reg/rnd_cnt = 0. Reset mid-schedule aborts it; the pending key is dropped.
//  - IDLE:
//    - busy_o=0, key_valid_o=0.
//    - start_i=1: key_reg<=key_i, rnd_cnt<=10, go to EMIT.
//    - First key_valid_o is asserted on the cycle after start_i.
//  - EMIT:
//    - Outputs: busy_o=1, key_valid_o=1, key_o=key_reg, rnd_o=rnd_cnt.
//    - Backpressure: while key_ready_i=0, key_o/rnd_o are held stable.
//    - Transfer (valid&ready), rnd_cnt>0: key_reg<=inv_step(key_reg,rnd_cnt), rnd_cnt--. The next key is valid the following cycle, giving 1 key/cycle throughput.
//    - Transfer, rnd_cnt==0: go to IDLE; done_o=1 for exactly one cycle (the cycle after the transfer).
//  - inv_step(K_r = a0..a3, r):
//    - b3=a3^a2, b2=a2^a1, b1=a1^a0.
//    - b0 = a0 ^ SubWord(RotWord(b3)) ^ {RCON[r-1],24'h0}.
//    - RotWord(x) = {x[23:0],x[31:24]}; RCON[0..9] = 01,02,04,08,10,20,40,80,1B,36.
//  - start_i while busy_o=1 is ignored and has no effect on state.
//  - The SubWord path is purely combinational from key_reg.
// CONFIGURATION
//  AES_INV_KEY_FWD_EXPAND_EN defined:
//   - key_i is the cipher key.
//   - start_i goes to FWD with rnd_cnt=0.
//   - FWD applies 10 forward steps, one per cycle, reusing the same SubWord instance: w0'=w0^SubWord(RotWord(w3))^RCON[rnd_cnt], etc.
//   - When rnd_cnt reaches 10 the block enters EMIT. First key_valid_o comes 11 cycles after start.
//   - busy_o=1 during FWD; key_valid_o=0.
//  Not defined: the FWD state and forward datapath are absent; key_i is the round-10 key.
// STRUCTURE
//  - aes_pkg: aes_128, aes_word, the RCON constant array, the SBOX table, and the state enum {IDLE,FWD,EMIT}.
//  - Sub-module aes_sbox_word: 4 parallel S-box lookups, 32-bit in/out, combinational.
//  - Top: FSM, key_reg, rnd_cnt, step mux.
// TESTING
//  FIPS-197 A.1 vectors: K0=2b7e151628aed2a6abf7158809cf4f3c, K9=ac7766f319fadc2128d12941575c006e,
//  K10=d014f9a8c9ee2589e13f0cc8b6630ca6.
//  1) start_i with key_i=K10, ready=1 -> 11 consecutive valid cycles:
//     rnd 10 = K10, rnd 9 = K9, ..., rnd 0 = K0; then done_o pulse, busy_o=0.
//  2) ready=0 for 3 cycles at rnd_o=5 -> key_o/rnd_o unchanged; resumes at rnd 4 after ready=1.
//  3) start_i pulsed with a different key at rnd_o=7 -> ignored; remaining keys still match the K10 sequence.
//  4) nrst=0 at rnd_o=6 -> next cycle all outputs 0, IDLE.
//     A restart with K10 reproduces scenario 1 exactly.
//  5) Macro defined, key_i=K0 -> key_valid_o first at cycle 11 with K10, then K9, ..., K0 as in scenario 1.
//  6) Randomized keys vs. reference model: the forward-expanded K10 fed in must reproduce all 11 keys in reverse order.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, round constants and S-box table for the inverse key schedule.
package aes_pkg;

  typedef logic [127:0] aes_128;
  typedef logic [31:0]  aes_word;

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  // Padded to 16 entries so a 4-bit round index never selects outside the table.
  localparam logic [0:15][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic aes_word rot_word(input aes_word x);
    return {x[23:0], x[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES S-box lookups on a 32-bit word, purely combinational.
module aes_sbox_word
  import aes_pkg::*;
(
  input  aes_word word,
  output aes_word subst
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign subst[8*i +: 8] = SBOX[word[8*i +: 8]];
  end

endmodule

// File: rtl/aes_inv_key_gen.sv
// Reverse AES-128 key schedule: emits round keys 10..0 over valid/ready.
// Define AES_INV_KEY_FWD_EXPAND_EN to load the cipher key and expand forward first.
module aes_inv_key_gen
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic             key_ready_i,
  output logic             key_valid_o,
  output logic [KEY_W-1:0] key_o,
  output logic [3:0]       rnd_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t     state, state_nxt;
  aes_128     key_reg, key_nxt;
  logic [3:0] rnd_cnt, rnd_nxt;
  logic       done_q, done_nxt;

  aes_word a0, a1, a2, a3;
  aes_word sub_in, sub_out;
  aes_128  inv_key;

  assign {a0, a1, a2, a3} = key_reg;

  // One S-box word shared by the forward and inverse steps.
`ifdef AES_INV_KEY_FWD_EXPAND_EN
  assign sub_in = (state == FWD) ? rot_word(a3) : rot_word(a3 ^ a2);
`else
  assign sub_in = rot_word(a3 ^ a2);
`endif

  aes_sbox_word u_sbox (
    .word  (sub_in),
    .subst (sub_out)
  );

  assign inv_key = {a0 ^ sub_out ^ {RCON[rnd_cnt - 4'd1], 24'h0},
                    a1 ^ a0, a2 ^ a1, a3 ^ a2};

`ifdef AES_INV_KEY_FWD_EXPAND_EN
  aes_word w0, w1, w2, w3;
  assign w0 = a0 ^ sub_out ^ {RCON[rnd_cnt], 24'h0};
  assign w1 = a1 ^ w0;
  assign w2 = a2 ^ w1;
  assign w3 = a3 ^ w2;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= IDLE;
      key_reg <= '0;
      rnd_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      key_reg <= key_nxt;
      rnd_cnt <= rnd_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_reg;
    rnd_nxt   = rnd_cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          key_nxt = key_i;
`ifdef AES_INV_KEY_FWD_EXPAND_EN
          state_nxt = FWD;
          rnd_nxt   = 4'd0;
`else
          state_nxt = EMIT;
          rnd_nxt   = 4'(NR);
`endif
        end
      end
`ifdef AES_INV_KEY_FWD_EXPAND_EN
      FWD: begin
        key_nxt = {w0, w1, w2, w3};
        rnd_nxt = rnd_cnt + 4'd1;
        if (rnd_cnt == 4'(NR - 1)) state_nxt = EMIT;
      end
`endif
      EMIT: begin
        if (key_ready_i) begin
          if (rnd_cnt != 4'd0) begin
            key_nxt = inv_key;
            rnd_nxt = rnd_cnt - 4'd1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign key_valid_o = (state == EMIT);
  assign busy_o      = (state != IDLE);
  assign key_o       = key_reg;
  assign rnd_o       = rnd_cnt;
  assign done_o      = done_q;

endmodule

// File: tb/tb_aes_inv_key_gen.sv
// Bench for aes_inv_key_gen: reference keys come from a forward FIPS-197
// expansion whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_inv_key_gen;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         key_ready_i = 1'b0;
  logic         key_valid_o;
  logic [127:0] key_o;
  logic [3:0]   rnd_o;
  logic         busy_o;
  logic         done_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk [11];

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

`ifdef AES_INV_KEY_FWD_EXPAND_EN
  localparam int LAT = 11;
  localparam bit LOAD_K0 = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit LOAD_K0 = 1'b0;
`endif

  aes_inv_key_gen dut (
    .clk         (clk),
    .nrst        (nrst),
    .start_i     (start_i),
    .key_i       (key_i),
    .key_ready_i (key_ready_i),
    .key_valid_o (key_valid_o),
    .key_o       (key_o),
    .rnd_o       (rnd_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        repeat (254) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Standard forward expansion into 44 words; rk[r] holds round key r.
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic kick();
    key_i   = LOAD_K0 ? rk[0] : rk[10];
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (key_valid_o !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; key_ready_i = 1'b1; start_i = 1'b1; key_i = K10;
    repeat (2) @(negedge clk);
    checks++;
    if (key_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags valid=%b busy=%b done=%b required 0 0 0", key_valid_o, busy_o, done_o);
    end
    checks++;
    if (key_o !== 128'h0 || rnd_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_data key=%h rnd=%0d required 0 0", key_o, rnd_o);
    end
    start_i = 1'b0; nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips();
    int n;
    expand(K0);
    checks++;
    if (rk[10] !== K10 || rk[9] !== K9) begin
      errors++;
      $display("FAIL model_vectors k10=%h k9=%h required %h %h", rk[10], rk[9], K10, K9);
    end
    key_ready_i = 1'b1;
    kick();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL fips_busy busy=%b required 1", busy_o);
    end
    wait_valid(n);
    checks++;
    if (n !== LAT - 1) begin
      errors++;
      $display("FAIL fips_latency cycles=%0d required %0d", n + 1, LAT);
    end
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (key_valid_o !== 1'b1 || rnd_o !== 4'(r) || key_o !== rk[r]) begin
        errors++;
        $display("FAIL fips_key v=%b rnd=%0d key=%h required 1 %0d %h", key_valid_o, rnd_o, key_o, r, rk[r]);
      end
      @(negedge clk);
    end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || key_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL fips_done done=%b busy=%b valid=%b required 1 0 0", done_o, busy_o, key_valid_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL fips_done_pulse done=%b required 0", done_o);
    end
  endtask

  task automatic test_backpressure();
    int n;
    expand(K0);
    key_ready_i = 1'b1;
    kick();
    wait_valid(n);
    for (int r = 10; r >= 0; r--) begin
      if (r == 5) begin
        key_ready_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (key_valid_o !== 1'b1 || rnd_o !== 4'd5 || key_o !== rk[5]) begin
            errors++;
            $display("FAIL stall_hold v=%b rnd=%0d key=%h required 1 5 %h", key_valid_o, rnd_o, key_o, rk[5]);
          end
        end
        key_ready_i = 1'b1;
      end
      checks++;
      if (key_valid_o !== 1'b1 || rnd_o !== 4'(r) || key_o !== rk[r]) begin
        errors++;
        $display("FAIL stall_key v=%b rnd=%0d key=%h required 1 %0d %h", key_valid_o, rnd_o, key_o, r, rk[r]);
      end
      @(negedge clk);
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_done done=%b required 1", done_o);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int n;
    expand(K0);
    key_ready_i = 1'b1;
    kick();
    wait_valid(n);
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (key_valid_o !== 1'b1 || rnd_o !== 4'(r) || key_o !== rk[r]) begin
        errors++;
        $display("FAIL ignore_key v=%b rnd=%0d key=%h required 1 %0d %h", key_valid_o, rnd_o, key_o, r, rk[r]);
      end
      if (r == 7) begin
        start_i = 1'b1;
        key_i   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      start_i = 1'b0;
    end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done done=%b busy=%b required 1 0", done_o, busy_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    expand(K0);
    key_ready_i = 1'b1;
    kick();
    wait_valid(n);
    n = 0;
    while (rnd_o !== 4'd6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    nrst = 1'b0;
    @(negedge clk);
    checks++;
    if (key_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || key_o !== 128'h0 || rnd_o !== 4'h0) begin
      errors++;
      $display("FAIL midreset v=%b busy=%b done=%b key=%h rnd=%0d required all 0",
               key_valid_o, busy_o, done_o, key_o, rnd_o);
    end
    nrst = 1'b1;
    @(negedge clk);
    kick();
    wait_valid(n);
    checks++;
    if (n !== LAT - 1) begin
      errors++;
      $display("FAIL restart_latency cycles=%0d required %0d", n + 1, LAT);
    end
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (key_valid_o !== 1'b1 || rnd_o !== 4'(r) || key_o !== rk[r]) begin
        errors++;
        $display("FAIL restart_key v=%b rnd=%0d key=%h required 1 %0d %h", key_valid_o, rnd_o, key_o, r, rk[r]);
      end
      @(negedge clk);
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_done done=%b required 1", done_o);
    end
  endtask

  // Random keys, started back-to-back right after each done pulse.
  task automatic test_random();
    int n;
    for (int t = 0; t < 5; t++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      key_ready_i = 1'b1;
      kick();
      wait_valid(n);
      checks++;
      if (n !== LAT - 1) begin
        errors++;
        $display("FAIL rand_latency cycles=%0d required %0d", n + 1, LAT);
      end
      for (int r = 10; r >= 0; r--) begin
        if (($urandom & 3) == 0) begin
          key_ready_i = 1'b0;
          @(negedge clk);
          key_ready_i = 1'b1;
        end
        checks++;
        if (key_valid_o !== 1'b1 || rnd_o !== 4'(r) || key_o !== rk[r]) begin
          errors++;
          $display("FAIL rand_key v=%b rnd=%0d key=%h required 1 %0d %h", key_valid_o, rnd_o, key_o, r, rk[r]);
        end
        @(negedge clk);
      end
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL rand_done done=%b busy=%b required 1 0", done_o, busy_o);
      end
    end
  endtask

  initial begin
    build_sbox();
    @(negedge clk);
    test_reset();
    test_fips();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
